// File: rtl/fpdiv_pkg.sv
// Shared FSM state encoding, mux select encodings and output decode for the
// Goldschmidt divider control sequencer (fpdiv_ctrl).
package fpdiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_N = 3'd1,
    LD_D = 3'd2,
    IT_N = 3'd3,
    IT_D = 3'd4,
    REM  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [1:0] SEL3_IA    = 2'd0;
  localparam logic [1:0] SEL3_REGC  = 2'd1;
  localparam logic [1:0] SEL3_DENOM = 2'd2;

  localparam logic [1:0] SEL4_NUM   = 2'd0;
  localparam logic [1:0] SEL4_DENOM = 2'd1;
  localparam logic [1:0] SEL4_REGA  = 2'd2;
  localparam logic [1:0] SEL4_REGB  = 2'd3;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en_a;
    logic       en_b;
    logic       en_rem;
    logic [1:0] sel_mux3;
    logic [1:0] sel_mux4;
  } ctrl_t;

  // Moore output decode for one state; unlisted signals stay 0.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE: c = '0;
      LD_N: begin
        c.busy = 1'b1; c.en_a = 1'b1;
        c.sel_mux3 = SEL3_IA; c.sel_mux4 = SEL4_NUM;
      end
      LD_D: begin
        c.busy = 1'b1; c.en_b = 1'b1;
        c.sel_mux3 = SEL3_IA; c.sel_mux4 = SEL4_DENOM;
      end
      IT_N: begin
        c.busy = 1'b1; c.en_a = 1'b1;
        c.sel_mux3 = SEL3_REGC; c.sel_mux4 = SEL4_REGA;
      end
      IT_D: begin
        c.busy = 1'b1; c.en_b = 1'b1;
        c.sel_mux3 = SEL3_REGC; c.sel_mux4 = SEL4_REGB;
      end
      REM: begin
        c.busy = 1'b1; c.en_rem = 1'b1;
        c.sel_mux3 = SEL3_DENOM; c.sel_mux4 = SEL4_REGA;
      end
      DONE: c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fpdiv_ctrl.sv
// Control sequencer for the Goldschmidt divider datapath.
// Optional abort input enabled by defining FPDIV_CTRL_ABORT_EN.
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITER = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef FPDIV_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic       en_a,
  output logic       en_b,
  output logic       en_rem,
  output logic [1:0] sel_mux3,
  output logic [1:0] sel_mux4
);

  localparam int CW = (ITER > 0) ? $clog2(ITER + 1) : 1;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] iter_cnt;
  logic [CW-1:0] next_cnt;
  ctrl_t         ctrl;
  ctrl_t         next_ctrl;

  // Next-state, iteration count and output decode from the next state.
  always_comb begin
    next_state = state;
    next_cnt   = iter_cnt;
    case (state)
      IDLE: begin
        if (start) next_state = LD_N;
        else       next_state = IDLE;
      end
      LD_N: next_state = LD_D;
      LD_D: begin
        next_cnt = '0;
        if (ITER > 0) next_state = IT_N;
        else          next_state = REM;
      end
      IT_N: next_state = IT_D;
      IT_D: begin
        next_cnt = iter_cnt + CW'(1);
        if ((int'(iter_cnt) + 1) < ITER) next_state = IT_N;
        else                             next_state = REM;
      end
      REM:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
`ifdef FPDIV_CTRL_ABORT_EN
    if (abort && (state != IDLE) && (state != DONE)) begin
      next_state = IDLE;
    end else begin
      next_state = next_state;
    end
`endif
    next_ctrl = decode(next_state);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      iter_cnt <= '0;
      ctrl     <= '0;
    end else begin
      state    <= next_state;
      iter_cnt <= next_cnt;
      ctrl     <= next_ctrl;
    end
  end

  assign busy     = ctrl.busy;
  assign done     = ctrl.done;
  assign en_a     = ctrl.en_a;
  assign en_b     = ctrl.en_b;
  assign en_rem   = ctrl.en_rem;
  assign sel_mux3 = ctrl.sel_mux3;
  assign sel_mux4 = ctrl.sel_mux4;

endmodule
